// File: rtl/tile_config_loader.sv
// Word-wide tile configuration loader: streams an image plus XOR checksum into a shadow
// register, commits it atomically on a checksum match, and reads the active image back.
module tile_config_loader #(
    parameter int CONFIG_WIDTH = 146,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [WORD_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    rb_start,
    output logic [WORD_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CONFIG_WIDTH-1:0] config_data,
    output logic                    config_valid,
    output logic                    busy,
    output logic                    error
);

    localparam int NW    = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int SW    = NW * WORD_WIDTH;
    localparam int CNT_W = $clog2(NW + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(NW - 1);
    localparam logic [CNT_W-1:0] CKSUM_IDX = CNT_W'(NW);

    typedef enum logic [2:0] {IDLE, LOAD, CKSUM, COMMIT, READBACK} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        count;
    logic [WORD_WIDTH-1:0]   acc;
    logic [SW-1:0]           shadow;
    logic                    match;
    logic                    in_xfer;
    logic                    out_xfer;

    // Padding bits above CONFIG_WIDTH read back as zero.
    function automatic logic [WORD_WIDTH-1:0] cfg_word(input logic [CONFIG_WIDTH-1:0] cfg,
                                                       input logic [CNT_W-1:0] idx);
        logic [SW-1:0] padded;
        padded = SW'(cfg);
        return padded[int'(idx)*WORD_WIDTH +: WORD_WIDTH];
    endfunction

    assign busy     = (state != IDLE);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start)         state_nxt = LOAD;
                else if (rb_start) state_nxt = READBACK;
            end
            LOAD: begin
                in_ready = !abort;
                if (abort)                                   state_nxt = IDLE;
                else if (in_valid && (count == LAST_DATA))   state_nxt = CKSUM;
            end
            CKSUM: begin
                in_ready = !abort;
                if (abort)         state_nxt = IDLE;
                else if (in_valid) state_nxt = COMMIT;
            end
            COMMIT:   state_nxt = IDLE;
            READBACK: begin
                if (abort)                                  state_nxt = IDLE;
                else if (out_xfer && (count == CKSUM_IDX))  state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            acc          <= '0;
            shadow       <= '0;
            match        <= 1'b0;
            config_data  <= '0;
            config_valid <= 1'b0;
            error        <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= '0;
                        acc   <= '0;
                        error <= 1'b0;
                    end else if (rb_start) begin
                        count     <= '0;
                        acc       <= cfg_word(config_data, '0);
                        out_data  <= cfg_word(config_data, '0);
                        out_valid <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        shadow <= '0;
                        count  <= '0;
                    end else if (in_xfer) begin
                        shadow[int'(count)*WORD_WIDTH +: WORD_WIDTH] <= in_data;
                        acc   <= acc ^ in_data;
                        count <= count + CNT_W'(1);
                    end
                end
                CKSUM: begin
                    if (abort) begin
                        shadow <= '0;
                        count  <= '0;
                    end else if (in_xfer) begin
                        match <= (in_data == acc);
                    end
                end
                // The only place the active image changes outside reset.
                COMMIT: begin
                    if (match) begin
                        config_data  <= shadow[CONFIG_WIDTH-1:0];
                        config_valid <= 1'b1;
                    end else begin
                        error <= 1'b1;
                    end
                end
                READBACK: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                    end else if (out_xfer) begin
                        if (count == CKSUM_IDX) begin
                            out_valid <= 1'b0;
                        end else if (count == LAST_DATA) begin
                            out_data <= acc;
                            count    <= CKSUM_IDX;
                        end else begin
                            out_data <= cfg_word(config_data, count + CNT_W'(1));
                            acc      <= acc ^ cfg_word(config_data, count + CNT_W'(1));
                            count    <= count + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_config_loader.sv
// Directed bench for tile_config_loader: loads, bad checksum, abort, readback, padding, reset.
module tb_tile_config_loader;

    localparam int CW = 146;
    localparam int WW = 8;
    localparam int NW = 19;

    logic          clock = 1'b0;
    logic          reset, start, abort, in_valid, rb_start, out_ready;
    logic [WW-1:0] in_data;
    logic          in_ready, out_valid, config_valid, busy, error;
    logic [WW-1:0] out_data;
    logic [CW-1:0] config_data;

    tile_config_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rb_start(rb_start), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .config_data(config_data),
        .config_valid(config_valid), .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    int            tests = 0;
    int            fails = 0;
    logic [WW-1:0] img [NW];
    logic [CW-1:0] active_exp;
    logic [WW-1:0] rb_q [$];
    logic [CW-1:0] cfg_q [$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [CW-1:0] img_cfg();
        logic [NW*WW-1:0] p;
        for (int k = 0; k < NW; k++) p[k*WW +: WW] = img[k];
        return p[CW-1:0];
    endfunction

    function automatic logic [WW-1:0] img_xor();
        logic [WW-1:0] x;
        x = '0;
        for (int k = 0; k < NW; k++) x ^= img[k];
        return x;
    endfunction

    task automatic send_word(input logic [WW-1:0] d, input bit gaps);
        int n;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic begin_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("error_cleared", error, 1'b0);
    endtask

    // Full load; on return the checksum edge has just passed (DUT in COMMIT).
    task automatic load(input logic [WW-1:0] ck, input bit gaps, input bit good);
        cfg_q.push_back(good ? img_cfg() : active_exp);
        begin_load();
        for (int k = 0; k < NW; k++) send_word(img[k], gaps);
        send_word(ck, gaps);
        chk("cfg_hold_first_edge", config_data, active_exp);
    endtask

    task automatic check_commit(input bit good);
        logic [CW-1:0] e;
        tick();
        e = cfg_q.pop_front();
        chk("cfg_commit", config_data, e);
        chk("cfg_valid", config_valid, 1'b1);
        chk("error_flag", error, !good);
        chk("busy_after_commit", busy, 1'b0);
        active_exp = e;
    endtask

    task automatic readback();
        logic [NW*WW-1:0] p;
        logic [WW-1:0]    x;
        logic             v;
        bit               tog;
        int               n;
        p = (NW*WW)'(active_exp);
        x = '0;
        for (int k = 0; k < NW; k++) begin
            rb_q.push_back(p[k*WW +: WW]);
            x ^= p[k*WW +: WW];
        end
        rb_q.push_back(x);
        rb_start = 1'b1;
        tick();
        rb_start = 1'b0;
        tog = 1'b0;
        n = 0;
        while (rb_q.size() > 0 && n < 200) begin
            out_ready = tog;
            tog = !tog;
            v = out_valid;
            chk("rb_valid", out_valid, 1'b1);
            if (v) chk("rb_word", out_data, rb_q[0]);
            tick();
            n++;
            if (v && out_ready) void'(rb_q.pop_front());
        end
        out_ready = 1'b0;
        chk("rb_all_words", rb_q.size(), 0);
        chk("rb_out_valid_end", out_valid, 1'b0);
        chk("rb_busy_end", busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        rb_start = 1'b0; out_ready = 1'b0; in_data = '0;
        active_exp = '0;
        repeat (2) tick();
        chk("rst_cfg", config_data, '0);
        chk("rst_cfg_valid", config_valid, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hA5;
        tick();
        chk("idle_in_ready", in_ready, 1'b0);
        chk("idle_busy", busy, 1'b0);
        in_valid = 1'b0;

        // Test 1: ramp image with its correct XOR checksum.
        for (int k = 0; k < NW; k++) img[k] = 8'(k);
        load(img_xor(), 1'b0, 1'b1);
        chk("t1_valid_not_yet", config_valid, 1'b0);
        check_commit(1'b1);
        chk("t1_byte0", config_data[7:0], 8'h00);
        chk("t1_byte1", config_data[15:8], 8'h01);
        chk("t1_top", config_data[145:144], 2'b10);

        // Test 4: readback with out_ready toggling.
        readback();

        // Test 2: different image, wrong checksum; active config must not move.
        for (int k = 0; k < NW; k++) img[k] = 8'(8'h40 + k);
        load(img_xor() ^ 8'h01, 1'b0, 1'b0);
        check_commit(1'b0);

        // Test 3: gapped load aborted after word 10, then a full gapped load.
        for (int k = 0; k < NW; k++) img[k] = 8'($urandom);
        begin_load();
        for (int k = 0; k <= 10; k++) send_word(img[k], 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_abort_busy", busy, 1'b0);
        chk("t3_abort_in_ready", in_ready, 1'b0);
        chk("t3_abort_cfg", config_data, active_exp);
        chk("t3_abort_valid", config_valid, 1'b1);
        load(img_xor(), 1'b1, 1'b1);
        check_commit(1'b1);

        // Test 5: padding bits set in the last word.
        for (int k = 0; k < NW; k++) img[k] = 8'($urandom);
        img[NW-1] = 8'hFF;
        load(img_xor(), 1'b0, 1'b1);
        check_commit(1'b1);
        chk("t5_top", config_data[145:144], 2'b11);
        readback();

        // Test 6: reset in the middle of a load, then start and rb_start together.
        begin_load();
        for (int k = 0; k < 7; k++) send_word(img[k], 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        active_exp = '0;
        chk("t6_cfg", config_data, '0);
        chk("t6_valid", config_valid, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_error", error, 1'b0);
        start = 1'b1;
        rb_start = 1'b1;
        tick();
        start = 1'b0;
        rb_start = 1'b0;
        chk("t6_start_wins_ready", in_ready, 1'b1);
        chk("t6_start_wins_out_valid", out_valid, 1'b0);
        chk("t6_busy_load", busy, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_abort_busy", busy, 1'b0);
        chk("t6_cfg_after_abort", config_data, active_exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
